mpp_fetch_unit: RTL
===================

Name: mpp_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the mpp core.
- Sits between the core's decode stage and the program memory, which is selected by an active-low chip select.
- Replaces direct single-byte fetching by the core with a prefetch queue.
- Adds a variable-latency memory handshake and branch redirect with flush of queued and in-flight fetches.

Parameters:
- DATA_W, 8, instruction word width
- ADDR_W, 16, program address width
- DEPTH, 4, prefetch queue entries (power of two, >=2)
- RESET_PC, 0, fetch address after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- mem_cs_n  out  1  program memory chip select, active low; asserted for exactly one cycle per request
- mem_addr  out  ADDR_W  request address, valid while mem_cs_n=0
- mem_rdata  in  DATA_W  returned instruction word
- mem_rvalid  in  1  mem_rdata valid; earliest one cycle after the request cycle
- instr_valid  out  1  queue head available to the core
- instr_ready  in  1  core accepts head
- instr_data  out  DATA_W  head instruction
- instr_addr  out  ADDR_W  address of head instruction
- redirect_valid  in  1  branch/jump: restart fetch
- redirect_addr  in  ADDR_W  new fetch address
- fifo_count  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Clock and reset: one clock, clk; rst_n is synchronous and active-low. Reset is sampled on the rising edge of clk only.
- Reset values: fetch_pc=RESET_PC; queue empty; fifo_count=0; instr_valid=0; mem_cs_n=1; mem_addr=0; state IDLE.
- Reset mid-operation: also discards any outstanding response. mem_rvalid is ignored in the first cycle after reset.
- FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE: if count<DEPTH, go to REQ; else stay.
  - REQ: mem_cs_n=0 and mem_addr=fetch_pc, both registered outputs. Go to WAIT unconditionally.
  - WAIT: on mem_rvalid, push {fetch_pc, mem_rdata} and set fetch_pc=fetch_pc+1 (mod 2^ADDR_W, 0xFFFF wraps to 0x0000). Next state is REQ if space remains after this cycle's push/pop, else IDLE. Without mem_rvalid, stay in WAIT indefinitely.
  - DRAIN: wait for mem_rvalid and discard the data, then go to IDLE.
- Outstanding requests: at most one. A request is issued only if a queue slot is free, so a push never overflows.
- Throughput: minimum request-to-request spacing is 2 cycles.
- Head outputs: instr_valid = (count!=0). instr_data and instr_addr are driven from the head entry with no bubble. Pop occurs when instr_valid & instr_ready.
- Same-cycle push and pop: legal at any occupancy, including full and empty. count is unchanged. Pop on an empty queue cannot happen.
- Redirect: highest priority, below reset. In the redirect cycle:
  - the queue is cleared, and any push or pop that cycle is cancelled;
  - fetch_pc=redirect_addr;
  - instr_valid=0 from the next cycle.
- Redirect next state: from REQ or WAIT (request in flight, rvalid not in this cycle) go to DRAIN. From WAIT with rvalid in the same cycle, drop that data and go to IDLE. From IDLE or DRAIN, go to IDLE or remain in DRAIN respectively.
- Redirect while in DRAIN: updates fetch_pc only. The single pending response is still discarded.
- Spurious mem_rvalid in IDLE or REQ: ignored.
- instr_ready while instr_valid=0: ignored.

Decomposition:
- mpp_pkg holds:
  - the fetch_state_t enum (IDLE, REQ, WAIT, DRAIN);
  - default width constants MPP_DATA_W=8 and MPP_ADDR_W=16;
  - the queue entry struct {addr, data}.
- One sub-module: mpp_sync_fifo, parametrised on width and depth.
  - Ports: push, pop, and flush; head data; count.
  - Pointers wrap modulo DEPTH, with an extra count bit to distinguish full from empty.
  - Same-cycle push+pop is supported.
- The FSM, fetch_pc and redirect logic live in mpp_fetch_unit.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_rvalid toggling -> mem_cs_n=1, instr_valid=0, fifo_count=0. The first request after release has mem_addr=0x0000.
- Fill with stalled core:
  - Setup: DEPTH=4, instr_ready=0, memory returns 0x07, 0xC0, 0x44, 0xC1 one cycle after each request.
  - Response: after 4 fetches, fifo_count=4 and mem_cs_n stays 1. Head is instr_addr=0x0000, instr_data=0x07.
- Streaming: instr_ready=1 with 3-cycle memory latency -> core receives 0x07, 0xC0, 0x44, 0xC1, 0xCB at addresses 0..4 in order, with no duplicates or skips.
- Redirect in WAIT:
  - Stimulus: redirect to 0x0100 while the request for 0x0002 is outstanding; its rvalid returns 0xAA two cycles later.
  - Response: 0xAA is never presented. The next mem_addr=0x0100, and the queue is empty in the cycle after the redirect.
- Full boundary: at fifo_count=4, pop and an rvalid push in the same cycle -> count stays 4 and entry order is preserved.
- Wrap and mid-run reset:
  - Redirect to 0xFFFF -> successive fetch addresses are 0xFFFF, then 0x0000.
  - Assert rst_n=0 while in WAIT -> after reset the late rvalid is discarded and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mpp_pkg.sv
// Shared types and default widths for the mpp instruction-fetch front end.
package mpp_pkg;

    localparam int MPP_DATA_W = 8;
    localparam int MPP_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [MPP_ADDR_W-1:0] addr;
        logic [MPP_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/mpp_fetch_unit_if.sv
// Bundle of program-memory, core-side and redirect signals around the fetch unit.
interface mpp_fetch_unit_if import mpp_pkg::*; #(
    parameter int DATA_W = MPP_DATA_W,
    parameter int ADDR_W = MPP_ADDR_W,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              mem_cs_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;

    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output mem_cs_n, mem_addr,
        input  mem_rdata, mem_rvalid,
        output instr_valid, instr_data, instr_addr,
        input  instr_ready,
        input  redirect_valid, redirect_addr,
        output fifo_count
    );

    modport slave (
        input  mem_cs_n, mem_addr,
        output mem_rdata, mem_rvalid,
        input  instr_valid, instr_data, instr_addr,
        output instr_ready,
        output redirect_valid, redirect_addr,
        input  fifo_count
    );

endinterface

// File: rtl/mpp_sync_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra bit so full and empty differ.
module mpp_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // A push into a full queue alongside a pop lands in the slot the pop vacates.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q[IDX_W-1:0]] = push_data_i;
                wr_ptr_d = wr_ptr_q + (IDX_W+1)'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/mpp_fetch_unit.sv
// Instruction prefetch front end: one outstanding memory request feeding a small queue,
// with branch redirect that flushes queued data and discards the in-flight response.
module mpp_fetch_unit import mpp_pkg::*; #(
    parameter int                DATA_W   = MPP_DATA_W,
    parameter int                ADDR_W   = MPP_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    mpp_fetch_unit_if.master bus
);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam int               ENTRY_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              mem_cs_n_q, mem_cs_n_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic               push, pop, flush;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after_push;

    mpp_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({fetch_pc_q, bus.mem_rdata}),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (count)
    );

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        mem_cs_n_d       = 1'b1;
        mem_addr_d       = mem_addr_q;
        push             = 1'b0;
        pop              = (count != '0) && bus.instr_ready;
        flush            = 1'b0;
        count_after_push = count + CNT_W'(1) - CNT_W'(pop);

        case (state_q)
            IDLE:  if (count < FULL) state_d = REQ;
            REQ:   state_d = WAIT;
            WAIT: begin
                if (bus.mem_rvalid) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    state_d    = (count_after_push < FULL) ? REQ : IDLE;
                end
            end
            DRAIN: if (bus.mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Redirect wins over queue traffic; an in-flight request must still be drained.
        if (bus.redirect_valid) begin
            flush      = 1'b1;
            push       = 1'b0;
            pop        = 1'b0;
            fetch_pc_d = bus.redirect_addr;
            case (state_q)
                REQ:     state_d = DRAIN;
                WAIT:    state_d = bus.mem_rvalid ? IDLE : DRAIN;
                IDLE:    state_d = IDLE;
                default: ;
            endcase
        end

        if (state_d == REQ) begin
            mem_cs_n_d = 1'b0;
            mem_addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_cs_n_q <= 1'b1;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_cs_n_q <= mem_cs_n_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.mem_cs_n    = mem_cs_n_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = (count != '0);
    assign bus.instr_addr  = head[ENTRY_W-1:DATA_W];
    assign bus.instr_data  = head[DATA_W-1:0];
    assign bus.fifo_count  = count;

endmodule
